// File: rtl/instruction_memory_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port among N_REQ requesters.
// Tracks the owner of each in-flight read and flags returning data to that owner.
module instruction_memory_arbiter #(
    parameter int unsigned N_REQ             = 4,
    parameter int unsigned MEMORY_WIDTH      = 16,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11,
    parameter int unsigned READ_LATENCY      = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0]   req_addr,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [MEMORY_WIDTH-1:0]              req_data,
    output logic [N_REQ-1:0]                     req_data_valid,
    output logic                                 mem_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr,
    input  logic                                 mem_ready,
    input  logic [MEMORY_WIDTH-1:0]              mem_data
);

    localparam int unsigned PtrW = $clog2(N_REQ);

    logic [PtrW-1:0]              ptr_q, ptr_d;
    logic [PtrW-1:0]              cand;
    logic [PtrW-1:0]              idx;
    logic                         grant;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_arr [N_REQ];

    logic [READ_LATENCY-1:0]           pipe_valid_q;
    logic [READ_LATENCY-1:0][PtrW-1:0] pipe_owner_q;

    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            addr_arr[i] = req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
        end
    end

    // Walk offsets from farthest to nearest so the slot closest to ptr wins.
    always_comb begin
        cand = '0;
        idx  = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            idx = ptr_q + PtrW'(k);
            if (req_valid[idx]) begin
                cand = idx;
            end
        end
    end

    always_comb begin
        mem_valid = (|req_valid) && !reset;
        grant     = mem_valid && mem_ready;
        mem_addr  = mem_valid ? addr_arr[cand] : '0;
        req_ready = '0;
        req_ready[cand] = grant;
        ptr_d     = grant ? cand + 1'b1 : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            pipe_valid_q <= '0;
            pipe_owner_q <= '0;
        end else begin
            ptr_q           <= ptr_d;
            pipe_valid_q[0] <= grant;
            pipe_owner_q[0] <= cand;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_owner_q[i] <= pipe_owner_q[i-1];
            end
        end
    end

    always_comb begin
        req_data       = mem_data;
        req_data_valid = '0;
        if (pipe_valid_q[READ_LATENCY-1]) begin
            req_data_valid[pipe_owner_q[READ_LATENCY-1]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// Randomized scoreboard bench for instruction_memory_arbiter with a round-robin reference model
// and a fixed-latency memory model; responses are checked by a separate monitor.
module tb_instruction_memory_arbiter;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int AW      = 11;
    localparam int LAT     = 3;
    localparam int NCYC    = 600;
    localparam int RST_CYC = 300;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [W-1:0]    req_data;
    logic [N-1:0]    req_data_valid;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic [W-1:0]    mem_data;

    always #5 clk = ~clk;

    instruction_memory_arbiter #(
        .N_REQ            (N),
        .MEMORY_WIDTH     (W),
        .MEMORY_ADDR_WIDTH(AW),
        .READ_LATENCY     (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_data_valid(req_data_valid),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data)
    );

    typedef struct {
        int         due;
        int         owner;
        logic [W-1:0] data;
    } resp_t;

    resp_t        exp_q[$];
    logic [W-1:0] memory [2048];
    bit           hs_v [NCYC + LAT + 4];
    int           hs_a [NCYC + LAT + 4];

    int checks = 0;
    int errors = 0;
    int cyc    = -1;
    int model_ptr;

    logic [N-1:0]  exp_ready;
    logic          exp_mvalid;
    logic [AW-1:0] exp_maddr;
    logic [AW-1:0] addrs [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_ready  = '0;
        exp_mvalid = 1'b0;
        exp_maddr  = '0;
        model_ptr  = 0;
        exp_q.delete();
    endtask

    // Monitor: compares combinational outputs and pops due responses.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 0) begin
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                chk("mem_valid", 32'(mem_valid), 32'(exp_mvalid));
                chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    chk("data_valid", 32'(req_data_valid), 32'(1) << exp_q[0].owner);
                    chk("req_data", 32'(req_data), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end else begin
                    chk("data_valid_idle", 32'(req_data_valid), 32'(0));
                end
            end
        end
    end

    // Driver plus reference model.
    initial begin
        int  cand;
        bit  found;
        bit  hs;
        for (int i = 0; i < 2048; i++) memory[i] = W'($urandom);
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        mem_ready = 1'b0;
        mem_data  = '0;
        model_reset();

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            reset = (c < 3) || (c == RST_CYC + 1);

            for (int i = 0; i < N; i++) begin
                addrs[i] = AW'($urandom);
                req_addr[i*AW +: AW] = addrs[i];
            end
            if (c < 40) begin
                req_valid = '1;
                mem_ready = 1'b1;
            end else if (c < 80) begin
                req_valid = '0;
                req_valid[$urandom_range(0, N-1)] = 1'b1;
                mem_ready = ($urandom_range(0, 3) != 0);
            end else if (c < 150) begin
                req_valid = N'($urandom);
                mem_ready = ($urandom_range(0, 3) == 0);
            end else if (c < NCYC - LAT - 4) begin
                req_valid = N'($urandom);
                mem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = '0;
                mem_ready = 1'b1;
            end
            if (c == RST_CYC) begin
                req_valid = 4'b0010;
                mem_ready = 1'b1;
            end
            mem_data = (c >= LAT && hs_v[c-LAT]) ? memory[hs_a[c-LAT]] : W'($urandom);

            hs_v[c] = 1'b0;
            hs_a[c] = 0;
            if (reset) begin
                model_reset();
            end else begin
                found = 1'b0;
                cand  = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(model_ptr + k) % N]) begin
                        found = 1'b1;
                        cand  = (model_ptr + k) % N;
                    end
                end
                hs         = found && mem_ready;
                exp_mvalid = found;
                exp_maddr  = found ? addrs[cand] : '0;
                exp_ready  = '0;
                if (hs) begin
                    exp_ready[cand] = 1'b1;
                    exp_q.push_back('{due: c + LAT, owner: cand, data: memory[addrs[cand]]});
                    model_ptr = (cand + 1) % N;
                    hs_v[c]   = 1'b1;
                    hs_a[c]   = int'(addrs[cand]);
                end
            end
            cyc = c;

            // Reset arrives mid-cycle after a grant: the in-flight read must be dropped.
            if (c == RST_CYC) begin
                #2;
                reset = 1'b1;
                model_reset();
            end
        end

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
